serial_subtractor4: RTL and testbench
=====================================

SERIAL_SUBTRACTOR4 -- requirements
Module: serial_subtractor4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operands on A/B/c are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port A, input, WIDTH bits, the unsigned minuend.
REQ-007 The block SHALL have port B, input, WIDTH bits, the unsigned subtrahend.
REQ-008 The block SHALL have port c, input, 1 bit, the borrow-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: Diff holds a completed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts Diff.
REQ-011 The block SHALL have port Diff, output, WIDTH+1 bits: {borrow_out, difference}.

Function
REQ-012 Diff SHALL equal (A - B - c) mod 2^(WIDTH+1), i.e. Diff[WIDTH] = 1 iff A < B + c.
REQ-013 Computation SHALL be bit-serial: one full-subtractor stage, one bit per cycle, LSB first.
REQ-014 The FSM SHALL have exactly the states IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE with rst_n high; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE->CALC SHALL occur on an edge with in_valid & in_ready; that edge latches A, B and c into working registers and clears the bit counter.
REQ-017 In CALC, each edge SHALL compute one difference bit and update the running borrow; after the WIDTH-th bit the FSM SHALL move to DONE.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH clock edges after the accepting edge (4 for WIDTH=4).
REQ-019 Diff SHALL update only on the CALC->DONE edge; partial bits SHALL never appear on Diff.
REQ-020 In DONE, Diff and out_valid SHALL hold stable until an edge with out_ready=1; that edge SHALL move to IDLE.
REQ-021 After DONE->IDLE, Diff SHALL keep its last value and out_valid SHALL be 0.
REQ-022 The block SHALL NOT overlap operations: in_valid SHALL be ignored in CALC and DONE, and operand changes during CALC SHALL NOT affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 Back-to-back: if in_valid is high in the cycle after DONE->IDLE, the block SHALL accept on that edge; the minimum period is WIDTH+2 cycles per operation.

Reset
REQ-025 An edge with rst_n=0 SHALL force state IDLE, out_valid=0, Diff=0, working registers and counter to 0, regardless of state.
REQ-026 A reset during CALC or DONE SHALL discard the operation; no result SHALL be emitted for it.
REQ-027 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after rst_n returns high.

Verification
REQ-028 A=5, B=3, c=0, out_ready=1 -> out_valid 4 edges after accept, Diff=5'b00010.
REQ-029 A=3, B=5, c=0 -> Diff=5'b11110; A=0, B=0, c=1 -> Diff=5'b11111; A=15, B=15, c=1 -> Diff=5'b11111.
REQ-030 A=15, B=0, c=0 with out_ready=0 for 3 cycles after out_valid -> Diff=5'b01111 and out_valid held, in_ready=0 and in_valid ignored throughout; IDLE on the first edge with out_ready=1.
REQ-031 A=4, B=5, c=1 accepted, A/B changed to 0 on the next cycle -> Diff=5'b11110.
REQ-032 rst_n=0 for one edge two cycles into CALC -> out_valid=0, Diff=0, in_ready=1 next cycle; no result appears for the aborted operation.
REQ-033 Two operations with in_valid held high -> the second is accepted on the first edge after the first result's out_ready handshake; both Diff values are correct.

Source files
------------

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor: Diff = {borrow_out, A - B - c}, one full-subtractor stage
// per clock, LSB first, with valid/ready handshakes on operands and result.
module serial_subtractor4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Diff,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; in_ready is high only in IDLE out of reset, out_valid only in DONE.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             d_bit;
  logic             br_nxt;
  logic             last_bit;

  assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
      Diff  <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q   <= A;
        b_q   <= B;
        br_q  <= c;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state == CALC) begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        br_q  <= br_nxt;
        acc_q <= {d_bit, acc_q[WIDTH-1:1]};
        cnt_q <= cnt_q + 1'b1;
        if (last_bit) Diff <= {br_nxt, d_bit, acc_q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor4.sv
// Self-checking bench for serial_subtractor4: vector table, hand-written corner
// sequences and randomized operations checked against an arithmetic model.
module tb_serial_subtractor4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         c;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   Diff;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W:0]   exp;
    int           hold;
    bit           chg;
  } vec_t;

  vec_t tbl[6];

  serial_subtractor4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: plain modular arithmetic on integers.
  function automatic logic [W:0] model(input int a, input int b, input int ci);
    int r;
    r = a - b - ci;
    return r[W:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One full operation from IDLE: accept, wait for result, optional back-pressure.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W:0] exp, input int hold, input bit chg);
    logic [W:0] prev;
    logic [W:0] got;
    logic [W:0] want;
    int lat;
    A = a; B = b; c = ci;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    chk("in_ready_idle", in_ready, 1);
    prev = Diff;
    step();
    exp_q.push_back(exp);
    in_valid = chg;
    if (chg) begin A = '0; B = '0; c = 1'b0; end
    chk("in_ready_calc", in_ready, 0);
    chk("out_valid_calc", out_valid, 0);
    lat = 0;
    for (int i = 1; i <= 3 * W; i++) begin
      step();
      if (out_valid) begin lat = i; break; end
      chk("no_partial_diff", Diff, prev);
    end
    chk("latency", lat, W);
    got  = Diff;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("diff", got, want);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      A = W'($urandom_range(0, (1 << W) - 1));
      B = W'($urandom_range(0, (1 << W) - 1));
      step();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_diff", Diff, got);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("diff_kept", Diff, got);
  endtask

  initial begin
    int lat;
    logic [W:0] exp1;
    logic [W:0] exp2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;

    tbl[0] = '{a: 4'd5,  b: 4'd3,  ci: 1'b0, exp: 5'b00010, hold: 0, chg: 1'b0};
    tbl[1] = '{a: 4'd3,  b: 4'd5,  ci: 1'b0, exp: 5'b11110, hold: 0, chg: 1'b0};
    tbl[2] = '{a: 4'd0,  b: 4'd0,  ci: 1'b1, exp: 5'b11111, hold: 1, chg: 1'b0};
    tbl[3] = '{a: 4'd15, b: 4'd15, ci: 1'b1, exp: 5'b11111, hold: 0, chg: 1'b0};
    tbl[4] = '{a: 4'd15, b: 4'd0,  ci: 1'b0, exp: 5'b01111, hold: 3, chg: 1'b0};
    tbl[5] = '{a: 4'd4,  b: 4'd5,  ci: 1'b1, exp: 5'b11110, hold: 0, chg: 1'b1};

    // Reset with stimulus active to show in_ready is masked by rst_n.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    A = 4'd9; B = 4'd2; c = 1'b0;
    step(); step(); step();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_diff", Diff, 0);
    chk("reset_in_ready", in_ready, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].exp, tbl[i].hold, tbl[i].chg);

    // Abort: reset two cycles into CALC, then no result may ever appear.
    A = 4'd7; B = 4'd1; c = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("abort_out_valid", out_valid, 0);
    chk("abort_diff", Diff, 0);
    chk("abort_in_ready_low", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    for (int i = 0; i < 2 * W; i++) begin
      step();
      chk("abort_no_result", out_valid, 0);
    end

    // Back-to-back with in_valid held high across both operations.
    exp1 = 5'b01001;   // 12 - 3 - 0
    exp2 = 5'b11010;   // 2 - 7 - 1 = -6
    A = 4'd12; B = 4'd3; c = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    A = 4'd2; B = 4'd7; c = 1'b1;
    lat = 0;
    for (int i = 1; i <= 3 * W; i++) begin
      step();
      if (out_valid) begin lat = i; break; end
    end
    chk("b2b_latency1", lat, W);
    chk("b2b_diff1", Diff, exp1);
    step();
    chk("b2b_idle_in_ready", in_ready, 1);
    chk("b2b_idle_out_valid", out_valid, 0);
    step();
    chk("b2b_accept2", in_ready, 0);
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 3 * W; i++) begin
      step();
      if (out_valid) begin lat = i; break; end
    end
    chk("b2b_latency2", lat, W);
    chk("b2b_diff2", Diff, exp2);
    step();
    chk("b2b_done_in_ready", in_ready, 1);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rc = 1'($urandom_range(0, 1));
      do_op(ra, rb, rc, model(ra, rb, rc), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
